// File: rtl/imem_loader.sv
// imem_loader
// Owns the write side of the CPU instruction memory. A start pulse zero-fills
// the whole memory. The loader then accepts a byte stream over a valid/ready
// handshake and writes it sequentially from address 0, big-endian. A clean,
// word-aligned end of program raises cpu_enable to release the pipeline.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle load request (honoured in IDLE/RUN/ERROR)
//   s_valid/s_data/s_last/s_ready   program byte stream handshake
//   mem_we/mem_addr/mem_wdata       instruction memory byte write port
//   cpu_enable      CPU run enable
//   done            program loaded successfully
//   error           load failed (misaligned length or overflow)
//   byte_count      bytes accepted in the current/last load
module imem_loader #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_enable,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(MEM_BYTES);

  state_t              state_r, state_s;
  logic                mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [7:0]          mem_wdata_r, mem_wdata_s;
  logic                cpu_enable_r, cpu_enable_s;
  logic                done_r, done_s;
  logic                error_r, error_s;
  logic [ADDR_W:0]     byte_count_r, byte_count_s;
  logic                handshake_s;
  logic [ADDR_W:0]     count_inc_s;

  // s_ready is the only combinational output: it is a pure state decode.
  assign s_ready     = (state_r == ST_LOAD);
  assign handshake_s = s_valid && (state_r == ST_LOAD);
  assign count_inc_s = byte_count_r + (ADDR_W+1)'(1);

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_enable = cpu_enable_r;
  assign done       = done_r;
  assign error      = error_r;
  assign byte_count = byte_count_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decode; outputs are registered one cycle later.
  always_comb begin
    state_s      = state_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    cpu_enable_s = cpu_enable_r;
    done_s       = done_r;
    error_s      = error_r;
    byte_count_s = byte_count_r;

    case (state_r)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          // The first clear write (address 0) is presented in the cycle
          // right after start is sampled; run/status flags drop together.
          state_s      = ST_CLEAR;
          mem_we_s     = 1'b1;
          mem_addr_s   = {ADDR_W{1'b0}};
          mem_wdata_s  = 8'h00;
          byte_count_s = {(ADDR_W+1){1'b0}};
          cpu_enable_s = 1'b0;
          done_s       = 1'b0;
          error_s      = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_CLEAR: begin
        // mem_addr_r doubles as the sweep counter.
        if (mem_addr_r == LAST_ADDR) begin
          state_s  = ST_LOAD;
          mem_we_s = 1'b0;
        end else begin
          mem_we_s    = 1'b1;
          mem_addr_s  = mem_addr_r + ADDR_W'(1);
          mem_wdata_s = 8'h00;
        end
      end

      ST_LOAD: begin
        if (handshake_s) begin
          mem_we_s     = 1'b1;
          mem_addr_s   = byte_count_r[ADDR_W-1:0];
          mem_wdata_s  = s_data;
          byte_count_s = count_inc_s;
          if (s_last) begin
            if (count_inc_s[1:0] == 2'b00) begin
              state_s      = ST_RUN;
              cpu_enable_s = 1'b1;
              done_s       = 1'b1;
            end else begin
              state_s = ST_ERROR;
              error_s = 1'b1;
            end
          end else if (count_inc_s == FULL_COUNT) begin
            // Memory is full but the program has not ended.
            state_s = ST_ERROR;
            error_s = 1'b1;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        mem_addr_s   = {ADDR_W{1'b0}};
        mem_wdata_s  = 8'h00;
        cpu_enable_s = 1'b0;
        done_s       = 1'b0;
        error_s      = 1'b0;
        byte_count_s = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  // Output registers; reset clears everything immediately so no write escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= 8'h00;
      cpu_enable_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      byte_count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      cpu_enable_r <= cpu_enable_s;
      done_r       <= done_s;
      error_r      <= error_s;
      byte_count_r <= byte_count_s;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader with a 16-byte memory. Expected memory writes are
// queued when bytes are driven (or when a clear sweep is started) and popped
// by a monitor whenever the DUT strobes mem_we.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int MEM_BYTES = 16;
  localparam int ADDR_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_enable;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   byte_count;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;
  int  checks = 0;
  int  errors = 0;
  int  bc_model = 0;

  logic [7:0] prog[8] = '{8'h20, 8'h0D, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_enable (cpu_enable),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  // Write monitor: every mem_we cycle must match the head of the queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        assert ({mem_addr, mem_wdata} === {exp_w.addr, exp_w.data}) else begin
          errors++;
          $error("FAIL write: observed addr=%0h data=%0h expected addr=%0h data=%0h",
                 mem_addr, mem_wdata, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Pulse start, expect a full zero sweep, then s_ready in the 17th cycle.
  task automatic do_clear();
    int cyc;
    for (int i = 0; i < MEM_BYTES; i++) exp_q.push_back({4'(i), 8'h00});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_first_we", 32'(mem_we), 32'd1);
    chk("start_cpu_enable_low", 32'(cpu_enable), 32'd0);
    chk("start_done_low", 32'(done), 32'd0);
    chk("start_error_low", 32'(error), 32'd0);
    chk("start_byte_count_zero", 32'(byte_count), 32'd0);
    cyc = 1;
    while (s_ready !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("clear_ready_cycle", 32'(cyc), 32'd17);
    chk("clear_writes_drained", 32'(exp_q.size()), 32'd0);
    chk("clear_we_off_at_ready", 32'(mem_we), 32'd0);
    bc_model = 0;
  endtask

  // Drive one byte for one cycle; valid stays high afterwards.
  task automatic send_byte(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    chk("byte_ready", 32'(s_ready), 32'd1);
    if (s_ready === 1'b1) begin
      exp_q.push_back({bc_model[ADDR_W-1:0], d});
      bc_model++;
    end
    step();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_flags", {29'd0, cpu_enable, done, error}, 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);

    // Clear sweep then gapped normal load of two instructions.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], (i == 7));
      if (i != 7) idle();
    end
    chk("load_byte_count", 32'(byte_count), 32'd8);
    chk("load_done", 32'(done), 32'd1);
    chk("load_cpu_enable", 32'(cpu_enable), 32'd1);
    chk("load_error", 32'(error), 32'd0);
    chk("load_writes_drained", 32'(exp_q.size()), 32'd0);
    idle();

    // Reload from RUN, back-to-back 4-byte program.
    do_clear();
    send_byte(8'h13, 1'b0);
    send_byte(8'h57, 1'b0);
    send_byte(8'h9B, 1'b0);
    send_byte(8'hDF, 1'b1);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_byte_count", 32'(byte_count), 32'd4);
    idle();

    // Misaligned end: 6 bytes.
    do_clear();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), (i == 5));
    chk("misaligned_error", 32'(error), 32'd1);
    chk("misaligned_cpu_enable", 32'(cpu_enable), 32'd0);
    chk("misaligned_done", 32'(done), 32'd0);
    chk("misaligned_byte_count", 32'(byte_count), 32'd6);
    idle();

    // Overflow: 16 bytes, no end marker; the 17th is refused.
    do_clear();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + 3 * i), 1'b0);
    chk("overflow_error", 32'(error), 32'd1);
    chk("overflow_cpu_enable", 32'(cpu_enable), 32'd0);
    chk("overflow_byte_count", 32'(byte_count), 32'd16);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    chk("overflow_17th_not_ready", 32'(s_ready), 32'd0);
    step();
    chk("overflow_no_17th_write", 32'(mem_we), 32'd0);
    idle();

    // Reset in the middle of a load after 3 bytes.
    do_clear();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_flags", {29'd0, cpu_enable, done, error}, 32'd0);
    chk("midrst_byte_count", 32'(byte_count), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("postrst_s_ready", 32'(s_ready), 32'd0);
    chk("postrst_mem_we", 32'(mem_we), 32'd0);
    step();
    chk("postrst_idle_ready", 32'(s_ready), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
